fifo_module: RTL and testbench

Synchronous single-clock FIFO, 1024 × 16 bit by default, with block-RAM style storage, registered status flags, pointer counts and overflow/underflow error strobes. Sits between pixel/datapath stages as a rate-decoupling buffer, giving the datapath the same flag set as a vendor primitive FIFO.

---
 rtl/fifo_module.sv | 95 +++++++++
 tb/tb_fifo_module.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_module.sv
// Synchronous single-clock FIFO with registered flags, pointer counts and error strobes.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is standard read latency.
module fifo_module #(
  parameter int DATA_WIDTH          = 16,
  parameter int ADDR_WIDTH          = 10,
  parameter int ALMOST_EMPTY_OFFSET = 128,
  parameter int ALMOST_FULL_OFFSET  = 128
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  WRITE_EN,
  input  logic                  READ_EN,
  input  logic [DATA_WIDTH-1:0] FIFO_IN,
  output logic [DATA_WIDTH-1:0] FIFO_OUT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH-1:0] RDCOUNT,
  output logic [ADDR_WIDTH-1:0] WRCOUNT,
  output logic                  RDERR,
  output logic                  WRERR
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_OFFSET);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(DEPTH - ALMOST_FULL_OFFSET);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic [ADDR_WIDTH-1:0] rd_next;
  logic [ADDR_WIDTH-1:0] wr_next;
  logic                  do_wr;
  logic                  do_rd;

  // Both requests are judged against the registered (pre-edge) flags.
  always_comb begin
    do_wr      = ENABLE & WRITE_EN & ~FULL;
    do_rd      = ENABLE & READ_EN & ~EMPTY;
    rd_next    = RDCOUNT + ADDR_WIDTH'(do_rd);
    wr_next    = WRCOUNT + ADDR_WIDTH'(do_wr);
    count_next = count + (ADDR_WIDTH + 1)'(do_wr) - (ADDR_WIDTH + 1)'(do_rd);
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (RESET && do_wr)
      mem[WRCOUNT] <= FIFO_IN;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count        <= '0;
      RDCOUNT      <= '0;
      WRCOUNT      <= '0;
      EMPTY        <= 1'b1;
      FULL         <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      RDERR        <= 1'b0;
      WRERR        <= 1'b0;
    end else begin
      count        <= count_next;
      RDCOUNT      <= rd_next;
      WRCOUNT      <= wr_next;
      EMPTY        <= (count_next == '0);
      FULL         <= (count_next == DEPTH_C);
      ALMOST_EMPTY <= (count_next <= AE_C);
      ALMOST_FULL  <= (count_next >= AF_C);
      RDERR        <= ENABLE & READ_EN & EMPTY;
      WRERR        <= ENABLE & WRITE_EN & FULL;
    end
  end

`ifdef FIFO_FWFT_EN
  // Output register tracks the post-edge head; bypass when the head is being written this edge.
  always_ff @(posedge CLK) begin
    if (!RESET)
      FIFO_OUT <= '0;
    else if (count_next != '0)
      FIFO_OUT <= (do_wr && (rd_next == WRCOUNT)) ? FIFO_IN : mem[rd_next];
  end
`else
  always_ff @(posedge CLK) begin
    if (!RESET)
      FIFO_OUT <= '0;
    else if (do_rd)
      FIFO_OUT <= mem[RDCOUNT];
  end
`endif

endmodule

// File: tb/tb_fifo_module.sv
// Scoreboard bench for fifo_module: a queue-based model predicts every post-edge output set,
// a monitor process compares after each rising edge.
module tb_fifo_module;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int AE    = 128;
  localparam int AF    = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          empty, full, aempty, afull, rderr, wrerr;
  logic [AW-1:0] rdcount, wrcount;

  fifo_module #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ALMOST_EMPTY_OFFSET(AE),
    .ALMOST_FULL_OFFSET(AF)
  ) dut (
    .CLK(clk), .RESET(rst_n), .ENABLE(en), .WRITE_EN(we), .READ_EN(re),
    .FIFO_IN(din), .FIFO_OUT(dout), .EMPTY(empty), .FULL(full),
    .ALMOST_EMPTY(aempty), .ALMOST_FULL(afull), .RDCOUNT(rdcount),
    .WRCOUNT(wrcount), .RDERR(rderr), .WRERR(wrerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] out;
    logic          empty, full, aempty, afull, rderr, wrerr;
    logic [AW-1:0] rdc, wrc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_out = '0;
  int unsigned   n_rd = 0;
  int unsigned   n_wr = 0;
  int            checks = 0;
  int            failures = 0;
  bit            stim_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // One clock of stimulus; the model advances by the same rules and queues its prediction.
  task automatic step(input bit r, input bit e, input bit w, input bit rd, input logic [DW-1:0] d);
    exp_t x;
    bit   was_empty, was_full;
    @(negedge clk);
    rst_n = r; en = e; we = w; re = rd; din = d;
    x.rderr = 1'b0;
    x.wrerr = 1'b0;
    if (!r) begin
      model_q.delete();
      model_out = '0;
      n_rd = 0;
      n_wr = 0;
    end else if (e) begin
      was_empty = (model_q.size() == 0);
      was_full  = (model_q.size() == DEPTH);
      x.rderr = rd && was_empty;
      x.wrerr = w && was_full;
      if (rd && !was_empty) begin
        model_out = model_q.pop_front();
        n_rd++;
      end
      if (w && !was_full) begin
        model_q.push_back(d);
        n_wr++;
      end
`ifdef FIFO_FWFT_EN
      if (model_q.size() != 0) model_out = model_q[0];
`endif
    end
    x.out    = model_out;
    x.empty  = (model_q.size() == 0);
    x.full   = (model_q.size() == DEPTH);
    x.aempty = (model_q.size() <= AE);
    x.afull  = (model_q.size() >= DEPTH - AF);
    x.rdc    = AW'(n_rd % DEPTH);
    x.wrc    = AW'(n_wr % DEPTH);
    sb.push_back(x);
  endtask

  // Monitor: the DUT presents a fresh output set after every rising edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("fifo_out", 32'(dout), 32'(x.out));
        check("empty", 32'(empty), 32'(x.empty));
        check("full", 32'(full), 32'(x.full));
        check("almost_empty", 32'(aempty), 32'(x.aempty));
        check("almost_full", 32'(afull), 32'(x.afull));
        check("rderr", 32'(rderr), 32'(x.rderr));
        check("wrerr", 32'(wrerr), 32'(x.wrerr));
        check("rdcount", 32'(rdcount), 32'(x.rdc));
        check("wrcount", 32'(wrcount), 32'(x.wrc));
      end
    end
  end

  initial begin : stimulus
    repeat (5) step(0, 0, 0, 0, '0);
    // Fill: 20,30,40,50 then 1..1020, then three rejected writes.
    step(1, 1, 1, 0, 16'd20);
    step(1, 1, 1, 0, 16'd30);
    step(1, 1, 1, 0, 16'd40);
    step(1, 1, 1, 0, 16'd50);
    for (int i = 1; i <= 1020; i++) step(1, 1, 1, 0, DW'(i));
    for (int i = 1021; i <= 1023; i++) step(1, 1, 1, 0, DW'(i));
    // Drain, then three rejected reads.
    for (int i = 0; i < 1024; i++) step(1, 1, 0, 1, '0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, '0);
    // Small interleave.
    step(1, 1, 1, 0, 16'd20);
    step(1, 1, 1, 0, 16'd30);
    step(1, 1, 1, 0, 16'd40);
    step(1, 1, 0, 1, '0);
    step(1, 1, 1, 0, 16'd60);
    step(1, 1, 0, 1, '0);
    // Simultaneous read+write when empty, then when full.
    step(0, 0, 0, 0, '0);
    step(1, 1, 1, 1, 16'hA5A5);
    step(1, 1, 0, 1, '0);
    for (int i = 0; i < DEPTH; i++) step(1, 1, 1, 0, DW'($urandom));
    step(1, 1, 1, 1, 16'h5A5A);
    step(1, 1, 1, 1, 16'h1234);
    // ENABLE low freezes everything regardless of requests.
    for (int i = 0; i < 8; i++) step(1, 0, i[0], i[1], DW'($urandom));
    // Random traffic with phases biased toward filling and draining, plus rare resets.
    for (int i = 0; i < 6000; i++) begin
      int unsigned wp;
      wp = ((i / 1500) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 999) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < 100 - wp),
           DW'($urandom));
    end
    step(1, 0, 0, 0, '0);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, stimulus not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
